updown_mod_counter: RTL and testbench
=====================================

Name: updown_mod_counter

Overview:
- Parametrised modulo counter with run-time direction, synchronous clear/load, and wrap or saturate policy.
- Successor to the single-direction 0..MAX clock counter; the same block serves seconds, minutes and hours digits in the up/down clock.
- Provides a combinational terminal-count output for same-cycle cascading, plus registered carry/borrow pulses for status and LEDs.
- Stages cascade by driving the next stage's enable from this stage's tc.

Parameters:
OUT_WIDTH, 6, width of count, load_val and internal arithmetic.
MIN_COUNT, 0, lowest legal count value; must satisfy MIN_COUNT <= MAX_COUNT < 2**OUT_WIDTH.
MAX_COUNT, 59, highest legal count value.
WRAP, 1, 1 = wrap at range boundary; 0 = saturate at range boundary.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
enable  in  1  count-step qualifier, one step per clock while high.
up_dn  in  1  1 = count up, 0 = count down; sampled only when enable=1.
clr  in  1  synchronous clear to MIN_COUNT.
load  in  1  synchronous load of load_val.
load_val  in  OUT_WIDTH  value to load; clamped into range.
count  out  OUT_WIDTH  current count, registered.
tc  out  1  combinational terminal count = enable & ~clr & ~load & (up_dn ? count==MAX_COUNT : count==MIN_COUNT).
carry  out  1  registered one-cycle pulse, up-wrap occurred.
borrow  out  1  registered one-cycle pulse, down-wrap occurred.
at_min  out  1  registered flag, count==MIN_COUNT.
at_max  out  1  registered flag, count==MAX_COUNT.

Behaviour:
- Reset (asynchronous, rst=1):
  - count=MIN_COUNT, carry=0, borrow=0, at_min=1, at_max=(MIN_COUNT==MAX_COUNT).
  - Holds while rst is high; first update on the first rising edge after deassert.
- Priority per rising edge: rst > clr > load > enable > hold.
- clr: count<=MIN_COUNT; carry=borrow=0.
- load:
  - count <= load_val when MIN_COUNT <= load_val <= MAX_COUNT.
  - count <= MAX_COUNT when load_val > MAX_COUNT; count <= MIN_COUNT when load_val < MIN_COUNT.
  - Never produces carry or borrow.
- enable, up_dn=1:
  - count<MAX: count+1.
  - count==MAX with WRAP=1: count<=MIN, carry<=1.
  - count==MAX with WRAP=0: hold at MAX, no carry.
- enable, up_dn=0:
  - count>MIN: count-1.
  - count==MIN with WRAP=1: count<=MAX, borrow<=1.
  - count==MIN with WRAP=0: hold at MIN, no borrow.
- carry/borrow:
  - High exactly one cycle, coincident with the wrapped count value.
  - Deasserted on every other edge; never both high together.
- tc: pure combinational, no latency; asserted in the cycle before a wrap, in both WRAP and saturate modes.
- at_min/at_max: always consistent with count in the same cycle, i.e. computed from the next-count value.
- Arithmetic: unsigned, OUT_WIDTH bits. Because the range check precedes the step, count never leaves [MIN,MAX], including when MAX_COUNT = 2**OUT_WIDTH-1.
- Degenerate MIN==MAX:
  - count is constant.
  - WRAP=1: every enabled step pulses carry (up) or borrow (down).
- Mid-operation events:
  - up_dn toggling between steps takes effect on the next enabled edge.
  - rst assertion at any time overrides immediately.

Optional Feature:
- Macro BCD_OUT_EN.
- When defined:
  - Adds outputs bcd_tens[3:0] and bcd_units[3:0], the registered BCD of count, updated on the same edge as count.
  - Reset value is the BCD of MIN_COUNT.
  - Valid for MAX_COUNT <= 99; a compile-time check errors otherwise.
- When undefined: the ports and their logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/header counter_pkg:
  - UP=1'b1 and DN=1'b0 constants.
  - MODE_WRAP=1 and MODE_SAT=0 constants.
  - clog2 function for sizing OUT_WIDTH from MAX_COUNT.
- Sub-module bin_to_bcd99: combinational 7-bit to two-digit BCD, instantiated only under BCD_OUT_EN.

Test Plan:
- Reset, then up-count: defaults, rst pulse, enable=1, up_dn=1 for 61 cycles -> count 0..59 then 0; carry=1 only in the cycle count returns to 0; tc=1 only while count==59.
- Down-wrap: from reset, up_dn=0, enable=1 -> count 59 after 1 edge with borrow=1 that cycle, then 58, 57.
- Load priority and clamping: load=1, load_val=63 -> count 59; load_val=20 with enable=1, up_dn=1 in the same cycle -> count 20, not 21; clr together with load -> count 0.
- Saturate mode: WRAP=0, MIN=1, MAX=12; load 12, up for 3 edges -> stays 12, carry=0, at_max=1; down from 1 -> stays 1.
- Asynchronous reset mid-count: count=37, assert rst between edges -> count=0 immediately, carry=borrow=0.
- Cascade: two instances (mod 60 seconds -> mod 60 minutes, minutes enable=seconds tc); load 59/05, one up edge -> 00/06 on the same edge. With BCD_OUT_EN, minutes tens=0, units=6.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and sizing helper for the up/down modulo counter family.
package counter_pkg;

  localparam logic UP = 1'b1;
  localparam logic DN = 1'b0;

  localparam int MODE_WRAP = 1;
  localparam int MODE_SAT  = 0;

  // Bits needed to represent 'value' distinct codes (use clog2(MAX_COUNT+1)).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd99.sv
// Combinational 7-bit binary to two-digit BCD; inputs above 99 are not meaningful.
module bin_to_bcd99 (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units
);

  always_comb begin
    tens  = 4'(bin / 7'd10);
    units = 4'(bin % 7'd10);
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with clear, clamped load and wrap/saturate policy.
// Define BCD_OUT_EN to add registered bcd_tens/bcd_units outputs (MAX_COUNT <= 99).
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int OUT_WIDTH = 6,
  parameter int MIN_COUNT = 0,
  parameter int MAX_COUNT = 59,
  parameter int WRAP      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 up_dn,
  input  logic                 clr,
  input  logic                 load,
  input  logic [OUT_WIDTH-1:0] load_val,
  output logic [OUT_WIDTH-1:0] count,
  output logic                 tc,
  output logic                 carry,
  output logic                 borrow,
  output logic                 at_min,
  output logic                 at_max
`ifdef BCD_OUT_EN
  ,
  output logic [3:0]           bcd_tens,
  output logic [3:0]           bcd_units
`endif
);

  localparam logic [OUT_WIDTH-1:0] MIN_V = OUT_WIDTH'(MIN_COUNT);
  localparam logic [OUT_WIDTH-1:0] MAX_V = OUT_WIDTH'(MAX_COUNT);
  localparam logic AT_MAX_RST = (MIN_COUNT == MAX_COUNT);

  if (MIN_COUNT > MAX_COUNT || MIN_COUNT < 0) begin : g_range_check
    $error("updown_mod_counter: MIN_COUNT must be in 0..MAX_COUNT");
  end
  if (clog2(MAX_COUNT + 1) > OUT_WIDTH) begin : g_width_check
    $error("updown_mod_counter: OUT_WIDTH too small for MAX_COUNT");
  end

  logic [OUT_WIDTH-1:0] count_q, count_d;
  logic                 carry_q, carry_d;
  logic                 borrow_q, borrow_d;
  logic                 at_min_q, at_min_d;
  logic                 at_max_q, at_max_d;
  int                   load_int;

  always_comb begin
    count_d  = count_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    // Widened so range comparisons stay meaningful at any OUT_WIDTH.
    load_int = int'(load_val);
    if (clr) begin
      count_d = MIN_V;
    end else if (load) begin
      if (load_int > MAX_COUNT)      count_d = MAX_V;
      else if (load_int < MIN_COUNT) count_d = MIN_V;
      else                           count_d = load_val;
    end else if (enable) begin
      if (up_dn == UP) begin
        if (count_q != MAX_V) begin
          count_d = count_q + OUT_WIDTH'(1);
        end else if (WRAP == MODE_WRAP) begin
          count_d = MIN_V;
          carry_d = 1'b1;
        end
      end else begin
        if (count_q != MIN_V) begin
          count_d = count_q - OUT_WIDTH'(1);
        end else if (WRAP == MODE_WRAP) begin
          count_d  = MAX_V;
          borrow_d = 1'b1;
        end
      end
    end
    at_min_d = (count_d == MIN_V);
    at_max_d = (count_d == MAX_V);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= MIN_V;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      at_min_q <= 1'b1;
      at_max_q <= AT_MAX_RST;
    end else begin
      count_q  <= count_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      at_min_q <= at_min_d;
      at_max_q <= at_max_d;
    end
  end

  // Same-cycle cascade: the next stage steps on the edge this one wraps or pins.
  assign tc     = enable & ~clr & ~load &
                  ((up_dn == UP) ? (count_q == MAX_V) : (count_q == MIN_V));
  assign count  = count_q;
  assign carry  = carry_q;
  assign borrow = borrow_q;
  assign at_min = at_min_q;
  assign at_max = at_max_q;

`ifdef BCD_OUT_EN
  if (MAX_COUNT > 99) begin : g_bcd_check
    $error("updown_mod_counter: BCD_OUT_EN requires MAX_COUNT <= 99");
  end

  localparam logic [3:0] TENS_RST  = 4'(MIN_COUNT / 10);
  localparam logic [3:0] UNITS_RST = 4'(MIN_COUNT % 10);

  logic [3:0] bcd_tens_q, bcd_tens_d;
  logic [3:0] bcd_units_q, bcd_units_d;

  bin_to_bcd99 u_bcd (
    .bin   (7'(count_d)),
    .tens  (bcd_tens_d),
    .units (bcd_units_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_tens_q  <= TENS_RST;
      bcd_units_q <= UNITS_RST;
    end else begin
      bcd_tens_q  <= bcd_tens_d;
      bcd_units_q <= bcd_units_d;
    end
  end

  assign bcd_tens  = bcd_tens_q;
  assign bcd_units = bcd_units_q;
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench: five counter configurations (incl. a seconds->minutes cascade)
// share randomized stimulus and are checked against an arithmetic reference model.
module tb_updown_mod_counter;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0, up_dn = 1'b0, clr = 1'b0, load = 1'b0;
  logic [5:0] load_val = '0, load_val_m = '0;

  logic [5:0] cnt0, cnt1;
  logic [3:0] cnt2;
  logic [2:0] cnt3, cnt4;
  logic [N-1:0] tc_v, cy_v, bw_v, amin_v, amax_v;
`ifdef BCD_OUT_EN
  logic [3:0] bcd_t [N];
  logic [3:0] bcd_u [N];
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // 0: seconds 0..59 wrap, 1: minutes 0..59 wrap enabled by seconds tc,
  // 2: 1..12 saturate, 3: degenerate 5..5 wrap, 4: 2..7 wrap at full 3-bit range
  updown_mod_counter #(.OUT_WIDTH(6), .MIN_COUNT(0), .MAX_COUNT(59), .WRAP(1)) u_sec (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt0), .tc(tc_v[0]), .carry(cy_v[0]), .borrow(bw_v[0]),
    .at_min(amin_v[0]), .at_max(amax_v[0])
`ifdef BCD_OUT_EN
    , .bcd_tens(bcd_t[0]), .bcd_units(bcd_u[0])
`endif
  );
  updown_mod_counter #(.OUT_WIDTH(6), .MIN_COUNT(0), .MAX_COUNT(59), .WRAP(1)) u_min (
    .clk(clk), .rst(rst), .enable(tc_v[0]), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val_m), .count(cnt1), .tc(tc_v[1]), .carry(cy_v[1]), .borrow(bw_v[1]),
    .at_min(amin_v[1]), .at_max(amax_v[1])
`ifdef BCD_OUT_EN
    , .bcd_tens(bcd_t[1]), .bcd_units(bcd_u[1])
`endif
  );
  updown_mod_counter #(.OUT_WIDTH(4), .MIN_COUNT(1), .MAX_COUNT(12), .WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .count(cnt2), .tc(tc_v[2]), .carry(cy_v[2]), .borrow(bw_v[2]),
    .at_min(amin_v[2]), .at_max(amax_v[2])
`ifdef BCD_OUT_EN
    , .bcd_tens(bcd_t[2]), .bcd_units(bcd_u[2])
`endif
  );
  updown_mod_counter #(.OUT_WIDTH(3), .MIN_COUNT(5), .MAX_COUNT(5), .WRAP(1)) u_deg (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[2:0]), .count(cnt3), .tc(tc_v[3]), .carry(cy_v[3]), .borrow(bw_v[3]),
    .at_min(amin_v[3]), .at_max(amax_v[3])
`ifdef BCD_OUT_EN
    , .bcd_tens(bcd_t[3]), .bcd_units(bcd_u[3])
`endif
  );
  updown_mod_counter #(.OUT_WIDTH(3), .MIN_COUNT(2), .MAX_COUNT(7), .WRAP(1)) u_full (
    .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[2:0]), .count(cnt4), .tc(tc_v[4]), .carry(cy_v[4]), .borrow(bw_v[4]),
    .at_min(amin_v[4]), .at_max(amax_v[4])
`ifdef BCD_OUT_EN
    , .bcd_tens(bcd_t[4]), .bcd_units(bcd_u[4])
`endif
  );

  function automatic int p_min(input int i);
    case (i)
      2: return 1;
      3: return 5;
      4: return 2;
      default: return 0;
    endcase
  endfunction
  function automatic int p_max(input int i);
    case (i)
      2: return 12;
      3: return 5;
      4: return 7;
      default: return 59;
    endcase
  endfunction
  function automatic int p_width(input int i);
    case (i)
      2: return 4;
      3, 4: return 3;
      default: return 6;
    endcase
  endfunction
  function automatic bit p_wrap(input int i);
    return (i != 2);
  endfunction

  function automatic int dut_cnt(input int i);
    case (i)
      0: return int'(cnt0);
      1: return int'(cnt1);
      2: return int'(cnt2);
      3: return int'(cnt3);
      default: return int'(cnt4);
    endcase
  endfunction

  function automatic void check_int(input string name, input int i, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%0d expected=%0d", name, i, $time, got, exp);
    end
  endfunction

  // Reference model: plain integer arithmetic on the documented rules.
  typedef struct { int cnt; bit cy; bit bw; } exp_t;
  int   m_cnt [N];
  bit   m_cy  [N];
  bit   m_bw  [N];
  exp_t exp_q [N][$];
  bit   tc_q  [N][$];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = p_min(i);
      m_cy[i]  = 1'b0;
      m_bw[i]  = 1'b0;
    end
  endfunction

  function automatic void model_step(input int i, input bit en, input bit u, input bit c,
                                     input bit l, input int lv);
    m_cy[i] = 1'b0;
    m_bw[i] = 1'b0;
    if (c) m_cnt[i] = p_min(i);
    else if (l) m_cnt[i] = (lv > p_max(i)) ? p_max(i) : ((lv < p_min(i)) ? p_min(i) : lv);
    else if (en && u) begin
      if (m_cnt[i] < p_max(i)) m_cnt[i] = m_cnt[i] + 1;
      else if (p_wrap(i)) begin m_cnt[i] = p_min(i); m_cy[i] = 1'b1; end
    end else if (en) begin
      if (m_cnt[i] > p_min(i)) m_cnt[i] = m_cnt[i] - 1;
      else if (p_wrap(i)) begin m_cnt[i] = p_max(i); m_bw[i] = 1'b1; end
    end
  endfunction

  task automatic step(input bit r, input bit e, input bit u, input bit c, input bit l,
                      input int lv, input int lvm);
    bit   tce [N];
    exp_t ex;
    @(negedge clk);
    rst = r; enable = e; up_dn = u; clr = c; load = l;
    load_val = 6'(lv); load_val_m = 6'(lvm);
    if (r) model_reset();
    for (int i = 0; i < N; i++) begin
      bit en_i;
      en_i = (i == 1) ? tce[0] : e;
      tce[i] = en_i && !c && !l && (u ? (m_cnt[i] == p_max(i)) : (m_cnt[i] == p_min(i)));
      tc_q[i].push_back(tce[i]);
    end
    for (int i = 0; i < N; i++) begin
      if (r) model_reset();
      else model_step(i, (i == 1) ? tce[0] : e, u, c, l,
                      (i == 1) ? lvm : (lv & ((1 << p_width(i)) - 1)));
      ex.cnt = m_cnt[i]; ex.cy = m_cy[i]; ex.bw = m_bw[i];
      exp_q[i].push_back(ex);
    end
  endtask

  // Assert rst between edges and check the outputs respond without a clock edge.
  task automatic async_reset_check();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < N; i++) begin
      check_int("async_rst_count", i, dut_cnt(i), p_min(i));
      check_int("async_rst_carry", i, int'(cy_v[i]), 0);
      check_int("async_rst_borrow", i, int'(bw_v[i]), 0);
      check_int("async_rst_at_min", i, int'(amin_v[i]), 1);
      check_int("async_rst_at_max", i, int'(amax_v[i]), (p_min(i) == p_max(i)) ? 1 : 0);
    end
  endtask

  // Registered-output monitor.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (exp_q[i].size() > 0) begin
          e = exp_q[i].pop_front();
          check_int("count", i, dut_cnt(i), e.cnt);
          check_int("carry", i, int'(cy_v[i]), int'(e.cy));
          check_int("borrow", i, int'(bw_v[i]), int'(e.bw));
          check_int("at_min", i, int'(amin_v[i]), (e.cnt == p_min(i)) ? 1 : 0);
          check_int("at_max", i, int'(amax_v[i]), (e.cnt == p_max(i)) ? 1 : 0);
`ifdef BCD_OUT_EN
          check_int("bcd_tens", i, int'(bcd_t[i]), e.cnt / 10);
          check_int("bcd_units", i, int'(bcd_u[i]), e.cnt % 10);
`endif
        end
      end
    end
  end

  // Combinational tc monitor, sampled mid-cycle after inputs settle.
  initial begin
    bit t;
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (tc_q[i].size() > 0) begin
          t = tc_q[i].pop_front();
          check_int("tc", i, int'(tc_v[i]), int'(t));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t got=running expected=finished", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    repeat (61) step(0, 1, 1, 0, 0, 0, 0);          // up-count with wrap
    step(0, 0, 0, 1, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0, 0);           // down-wrap 59, 58, 57
    step(0, 0, 0, 0, 1, 63, 63);                    // clamp above range
    step(0, 1, 1, 0, 1, 20, 20);                    // load beats enable
    step(0, 0, 0, 1, 1, 20, 20);                    // clr beats load
    step(0, 0, 0, 0, 1, 12, 12);
    repeat (3) step(0, 1, 1, 0, 0, 0, 0);           // saturate at top
    step(0, 0, 0, 0, 1, 1, 1);
    repeat (3) step(0, 1, 0, 0, 0, 0, 0);           // saturate at bottom
    step(0, 0, 0, 0, 1, 37, 37);
    async_reset_check();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 59, 5);                     // cascade 59/05
    step(0, 1, 1, 0, 0, 0, 0);                      // -> 00/06
    step(0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 299) == 0) async_reset_check();
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 29) == 0, $urandom_range(0, 11) == 0,
           int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
    end
    repeat (3) @(posedge clk);
    #2;
    for (int i = 0; i < N; i++) check_int("scoreboard_drain", i, exp_q[i].size() + tc_q[i].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
